// File: rtl/alien_fleet.sv
// Alien fleet: a ROWS x COLS grid of invaders that marches right and left, steps down
//   at the screen edges, dies to laser hits and paints its own sprites into the VGA stream.
// Ports: clk/reset (async active-low); step, restart; hPos/vPos pixel in; xLaser/yLaser/laserActive;
//   killingAlien pulse, alive vector, xFleet/yFleet, aliveCount, color, landed/cleared.
// Latency: position, alive and kill pulse update on the edge after the event; color and aliveCount
//   are one more register stage behind their sources. No backpressure: step and hits act when presented.
module alien_fleet #(
   parameter int         ROWS        = 4,
   parameter int         COLS        = 6,
   parameter int         CELL_LOG2   = 5,
   parameter int         ALIEN_W     = 24,
   parameter int         ALIEN_H     = 16,
   parameter int         STEP_X      = 4,
   parameter int         STEP_Y      = 8,
   parameter int         X_START     = 16,
   parameter int         Y_START     = 32,
   parameter int         X_MAX       = 639,
   parameter int         Y_LIMIT     = 440,
   parameter logic [2:0] ALIEN_COLOR = 3'b010
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 step,
   input  logic                 restart,
   input  logic [9:0]           hPos,
   input  logic [9:0]           vPos,
   input  logic [9:0]           xLaser,
   input  logic [9:0]           yLaser,
   input  logic                 laserActive,
   output logic                 killingAlien,
   output logic [ROWS*COLS-1:0] alive,
   output logic [9:0]           xFleet,
   output logic [9:0]           yFleet,
   output logic [7:0]           aliveCount,
   output logic [2:0]           color,
   output logic                 landed,
   output logic                 cleared
);

   localparam int N = ROWS * COLS;
   localparam logic [CELL_LOG2-1:0] SPR_W = CELL_LOG2'(ALIEN_W);
   localparam logic [CELL_LOG2-1:0] SPR_H = CELL_LOG2'(ALIEN_H);
   localparam logic [11:0] X_MAX_W   = 12'(X_MAX);
   localparam logic [11:0] Y_LIMIT_W = 12'(Y_LIMIT);
   localparam logic [11:0] STEP_X_W  = 12'(STEP_X);

   typedef enum logic [1:0] {MOVE_R, MOVE_L, LANDED, CLEARED} state_t;

   state_t         state_q, state_d;
   logic [9:0]     x_q, x_d, y_q, y_d;
   logic [N-1:0]   alive_q, alive_d;
   logic           kill_q, kill_d;
   logic [2:0]     color_q, color_d;
   logic [7:0]     count_q, count_d;

   // One-hot mask of the cell whose sprite box contains (px,py); zero in gaps or off-grid.
   // Off-grid rows/columns simply never match the unrolled compare.
   function automatic logic [N-1:0] sprite_mask(input logic [9:0] px, input logic [9:0] py,
                                                input logic [9:0] fx, input logic [9:0] fy);
      logic [N-1:0] m;
      logic [9:0]   dx, dy, col, row;
      m   = '0;
      dx  = px - fx;
      dy  = py - fy;
      col = dx >> CELL_LOG2;
      row = dy >> CELL_LOG2;
      if (px >= fx && py >= fy && dx[CELL_LOG2-1:0] < SPR_W && dy[CELL_LOG2-1:0] < SPR_H) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               if (row == 10'(r) && col == 10'(c)) m[r*COLS+c] = 1'b1;
            end
         end
      end
      return m;
   endfunction

   logic [N-1:0] hit_mask, pix_mask;
   assign hit_mask = sprite_mask(xLaser, yLaser, x_q, y_q) & alive_q;
   assign pix_mask = sprite_mask(hPos, vPos, x_q, y_q) & alive_q;

   // Extent of the surviving fleet, taken from the pre-hit alive vector.
   logic [COLS-1:0] col_live;
   logic [ROWS-1:0] row_live;
   logic [11:0]     min_col, max_col, max_row;
   logic [7:0]      live_cnt;

   always_comb begin
      col_live = '0;
      row_live = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (alive_q[r*COLS+c]) begin
               row_live[r] = 1'b1;
               col_live[c] = 1'b1;
            end
         end
      end
      min_col = '0;
      max_col = '0;
      max_row = '0;
      for (int c = COLS-1; c >= 0; c--) if (col_live[c]) min_col = 12'(c);
      for (int c = 0; c < COLS; c++)    if (col_live[c]) max_col = 12'(c);
      for (int r = 0; r < ROWS; r++)    if (row_live[r]) max_row = 12'(r);
      live_cnt = '0;
      for (int i = 0; i < N; i++) live_cnt = live_cnt + {7'd0, alive_q[i]};
   end

   // 12-bit arithmetic so edge + step cannot wrap past the 10-bit screen range.
   logic [11:0] left_edge, right_edge, bottom;
   assign left_edge  = {2'b00, x_q} + (min_col << CELL_LOG2);
   assign right_edge = {2'b00, x_q} + (max_col << CELL_LOG2) + 12'(ALIEN_W - 1);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      alive_d = alive_q;
      kill_d  = 1'b0;
      color_d = (|pix_mask) ? ALIEN_COLOR : 3'b000;
      count_d = live_cnt;
      bottom  = '0;
      if (restart) begin
         state_d = MOVE_R;
         x_d     = 10'(X_START);
         y_d     = 10'(Y_START);
         alive_d = '1;
         color_d = 3'b000;
         count_d = 8'(N);
      end else if (state_q == MOVE_R || state_q == MOVE_L) begin
         // A hit is judged against the pre-step position; both updates land together.
         if (laserActive) begin
            alive_d = alive_q & ~hit_mask;
            kill_d  = |hit_mask;
         end
         if (step) begin
            if (state_q == MOVE_R) begin
               if (right_edge + STEP_X_W <= X_MAX_W) begin
                  x_d = x_q + 10'(STEP_X);
               end else begin
                  y_d     = y_q + 10'(STEP_Y);
                  state_d = MOVE_L;
               end
            end else begin
               if (left_edge >= STEP_X_W) begin
                  x_d = x_q - 10'(STEP_X);
               end else begin
                  y_d     = y_q + 10'(STEP_Y);
                  state_d = MOVE_R;
               end
            end
         end
         bottom = {2'b00, y_d} + (max_row << CELL_LOG2) + 12'(ALIEN_H - 1);
         // Clearing the last alien wins over touching down in the same cycle.
         if (alive_d == '0)            state_d = CLEARED;
         else if (bottom >= Y_LIMIT_W) state_d = LANDED;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= MOVE_R;
         x_q     <= 10'(X_START);
         y_q     <= 10'(Y_START);
         alive_q <= '1;
         kill_q  <= 1'b0;
         color_q <= 3'b000;
         count_q <= 8'(N);
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         alive_q <= alive_d;
         kill_q  <= kill_d;
         color_q <= color_d;
         count_q <= count_d;
      end
   end

   assign killingAlien = kill_q;
   assign alive        = alive_q;
   assign xFleet       = x_q;
   assign yFleet       = y_q;
   assign aliveCount   = count_q;
   assign color        = color_q;
   assign landed       = (state_q == LANDED);
   assign cleared      = (state_q == CLEARED);

endmodule
